// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: register offsets, FSM states
// and the CPU-facing interrupt width.
package irq_pkg;

    localparam int HWINT_W = 6;

    localparam logic [1:0] IRQ_MASK = 2'd0;
    localparam logic [1:0] IRQ_MODE = 2'd1;
    localparam logic [1:0] IRQ_PEND = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;

    typedef enum logic {
        IRQ_IDLE   = 1'b0,
        IRQ_ACTIVE = 1'b1
    } irq_state_e;

    // Ids that do not fit the CPU-facing width map to no line at all.
    function automatic logic [HWINT_W-1:0] onehot_id(input logic [2:0] id);
        logic [HWINT_W-1:0] oh;
        oh = '0;
        for (int i = 0; i < HWINT_W; i++) begin
            oh[i] = (id == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Register-window bus between the bridge address decode and the sequencer.
interface irq_sequencer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder returning {valid, id}.
module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: level/edge capture, mask, fixed-priority dispatch of one
// request at a time, held one-hot to the CPU until the handler writes EOI.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic               clk,
    input  logic               sys_rstn,
    input  logic [N_SRC-1:0]   src,
    irq_sequencer_if.slave     bus,
    output logic [HWINT_W-1:0] hwint,
    output logic               busy
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic [N_SRC-1:0] rise, pend, eligible, w1c, eoi_clr;

    irq_state_e         state_q;
    logic [2:0]         cur_id_q;
    logic [HWINT_W-1:0] hwint_q;
    logic               busy_q;

    logic               wr_mask, wr_mode, wr_pend, wr_eoi;
    logic [N_SRC-1:0]   wd_src;
    logic               win_valid;
    logic [2:0]         win_id;
    logic [31:0]        rd_d;

    assign wd_src  = bus.wd[N_SRC-1:0];
    assign wr_mask = bus.we && (bus.addr == IRQ_MASK);
    assign wr_mode = bus.we && (bus.addr == IRQ_MODE);
    assign wr_pend = bus.we && (bus.addr == IRQ_PEND);
    assign wr_eoi  = bus.we && (bus.addr == IRQ_STAT);

    always_comb begin
        rise     = src & ~src_q;
        pend     = (mode_q & edge_q) | (~mode_q & src_q);
        eligible = pend & mask_q;
        mask_d   = wr_mask ? wd_src : mask_q;
        mode_d   = wr_mode ? wd_src : mode_q;
        w1c      = wr_pend ? wd_src : '0;
        eoi_clr  = '0;
        if (wr_eoi && (state_q == IRQ_ACTIVE)) begin
            for (int i = 0; i < N_SRC; i++) begin
                eoi_clr[i] = (cur_id_q == 3'(i));
            end
        end
        // Set beats clear; a bit only survives while it is edge mode both
        // before and after this edge, so level->edge starts cleared.
        edge_d = ((edge_q & ~(w1c | eoi_clr)) | rise) & mode_q & mode_d;
    end

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            src_q  <= '0;
            mask_q <= '0;
            mode_q <= '0;
            edge_q <= '0;
        end else begin
            src_q  <= src;
            mask_q <= mask_d;
            mode_q <= mode_d;
            edge_q <= edge_d;
        end
    end

    irq_prio_enc #(
        .N (N_SRC)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // No preemption: while ACTIVE only EOI matters; a stray EOI in IDLE is a no-op.
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q  <= IRQ_IDLE;
            cur_id_q <= '0;
            hwint_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (win_valid) begin
                        state_q  <= IRQ_ACTIVE;
                        cur_id_q <= win_id;
                        hwint_q  <= onehot_id(win_id);
                        busy_q   <= 1'b1;
                    end
                end
                IRQ_ACTIVE: begin
                    if (wr_eoi) begin
                        state_q <= IRQ_IDLE;
                        hwint_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    hwint_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (bus.addr)
            IRQ_MASK: rd_d[N_SRC-1:0] = mask_q;
            IRQ_MODE: rd_d[N_SRC-1:0] = mode_q;
            IRQ_PEND: rd_d[N_SRC-1:0] = pend;
            IRQ_STAT: rd_d = {busy_q, 28'b0, cur_id_q};
            default:  rd_d = '0;
        endcase
    end

    assign bus.rd = rd_d;
    assign hwint  = hwint_q;
    assign busy   = busy_q;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt controller between the system peripherals (timer, UART, IO, future sources) and the CPU's 6-bit `HWInt` input. It captures per-source requests as level or rising-edge, applies a software mask, and selects one request at a time by fixed priority. It then holds a one-hot interrupt line to the CPU until the handler writes end-of-interrupt (EOI). It is a slave on the bridge address decode, with a four-word register window.

## Interface
- `N_SRC`, default 6: number of interrupt sources, 1..8. The CPU-facing width stays 6; unused bits are tied 0.
- `clk` input 1: system CPU clock.
- `sys_rstn` input 1: asynchronous, active-low reset.
- `src` input `N_SRC`: raw requests, synchronous to `clk`, active high.
- `addr` input 2: word select, from `memAddr[3:2]`.
- `we` input 1: register write strobe from the bridge decode.
- `wd` input 32: write data.
- `rd` output 32: read data, combinational from `addr`.
- `hwint` output 6: one-hot request to the CPU `HWInt` input.
- `busy` output 1: a source is currently in service.

## Operation
- Registers:
  - `addr` 0, MASK, RW: bit i=1 enables source i.
  - `addr` 1, MODE, RW: bit i=1 selects rising-edge capture; 0 selects level.
  - `addr` 2, PEND: read gives pending bits. Write-1-clears edge-mode bits only; level bits ignore writes.
  - `addr` 3, STAT/EOI: read gives {`busy`, 28'b0, `cur_id`[2:0]}. Any write is an EOI.
- Bits at or above `N_SRC` read 0 and ignore writes.
- Capture:
  - `src_q` <= `src` every cycle.
  - Edge-mode pending bit sets when `src & ~src_q`, and stays set until W1C or EOI.
  - Level-mode pending bit = `src_q`.
- Eligible sources: `PEND & MASK`. Priority goes to the lowest index (0 highest).
- State machine, two states:
  - IDLE: if any source is eligible, latch `cur_id` = winner and go to ACTIVE. `hwint` = 0.
  - ACTIVE: `hwint` = one-hot(`cur_id`) and `busy` = 1. New or higher-priority requests only accumulate in PEND; there is no preemption. An EOI write returns the machine to IDLE, and if source `cur_id` is in edge mode its pending bit clears in the same edge.
- Boundary rules:
  - An edge arriving in the same cycle as a W1C or EOI clear of the same bit: set wins and the bit stays pending.
  - EOI written while IDLE: ignored.
  - MASK bit cleared while its source is ACTIVE: stays ACTIVE until EOI, with no retraction.
  - Level source still high after EOI: re-dispatched from IDLE on the following cycle.
  - MODE changed on a pending bit: edge→level immediately reflects `src_q`; level→edge starts with the bit cleared.
  - `sys_rstn` low mid-service: immediately aborts to IDLE.
- Reset values: MASK=0, MODE=0, PEND=0, `src_q`=0, `cur_id`=0, state=IDLE, `hwint`=0, `busy`=0.

## Timing
- `src` rises before clock edge k: `src_q` and the edge pending bit update at edge k. The state goes to ACTIVE at edge k+1, so `hwint` is high after k+1. Total latency is 2 cycles from request to `hwint`.
- EOI written at edge e: `hwint` and `busy` are 0 after e. The next dispatch happens no earlier than edge e+1.
- `rd` is combinational from `addr` and current register state; no read side effects.
- All state is flopped on `clk` rising edge and cleared asynchronously on `sys_rstn` falling.

## Structure
- Shared package `irq_pkg`:
  - register offsets `IRQ_MASK`, `IRQ_MODE`, `IRQ_PEND`, `IRQ_STAT`;
  - state enum {`IRQ_IDLE`, `IRQ_ACTIVE`};
  - `HWINT_W` = 6.
- One sub-module, `irq_prio_enc`: combinational N-bit lowest-index priority encoder giving {valid, id[2:0]}.
- Everything else is in one file: capture, registers, FSM, read mux.

## Test plan
- Reset: hold `sys_rstn`=0 with `src`=6'h3F → `hwint`=0, `busy`=0, all register reads 0. Release → still 0, since MASK=0.
- Level dispatch:
  - Stimulus: MASK=6'h3F, MODE=0, `src`[2]=1 at edge k.
  - Response: `hwint`=6'b000100 after k+1; STAT reads 32'h8000_0002.
  - Then drop `src`[2] and write EOI → `hwint`=0; no re-dispatch.
- Priority and no preemption:
  - Stimulus: `src`[4] active and in service, then `src`[0] rises.
  - Response: `hwint` stays 6'b010000 and PEND reads 6'h11.
  - After EOI with `src`[4] released → `hwint`=6'b000001 one cycle later.
- Edge capture:
  - Stimulus: MODE bit 1=1, one-cycle pulse on `src`[1].
  - Response: PEND[1] stays 1 after the pulse and `hwint`=6'b000010. After EOI → PEND[1]=0 and `hwint`=0.
  - Repeat with W1C of 6'h02 on the same cycle as a new edge → PEND[1] stays 1.
- Masking and stray EOI:
  - MASK=0 with `src`=6'h3F → `hwint` never asserts.
  - EOI while IDLE → no state change.
  - Clearing MASK bit 3 while source 3 is ACTIVE → `hwint` holds until EOI.
- Reset mid-operation: assert `sys_rstn`=0 while ACTIVE, asynchronously between clock edges → `hwint`=0 and `busy`=0 immediately; MASK reads 0 after release.
